// File: rtl/imm_extend_stage.sv
// Registered immediate extractor/extender for the LEGv8 decode stage (I, D, B, CB, IW formats).
// Optional macro IMM_BR_SHIFT_EN: B/CB results become byte offsets (shifted left by 2).
module imm_extend_stage #(
    parameter int OUT_W = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [2:0]       fmt,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] imm,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_D  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_CB = 3'd3;
    localparam logic [2:0] FMT_IW = 3'd4;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic iw_legal(input logic [1:0] hw);
        return (int'(hw) * 16 + 16) <= OUT_W;
    endfunction

    function automatic logic signed [OUT_W-1:0] br_scale(input logic signed [OUT_W-1:0] v);
`ifdef IMM_BR_SHIFT_EN
        return v <<< 2;
`else
        return v;
`endif
    endfunction

    logic signed [8:0]       fld_d;
    logic signed [25:0]      fld_b;
    logic signed [18:0]      fld_cb;
    logic signed [OUT_W-1:0] ext_i, ext_d, ext_b, ext_cb, ext_iw;
    logic signed [OUT_W-1:0] imm_p0;
    logic                    ill_p0;
    logic                    unused_opcode;

    state_t                  state_p1;
    logic signed [OUT_W-1:0] imm_p1;
    logic                    err_p1;
    logic [CNT_W-1:0]        cnt_p1;

    // ---- stage p0: field select and extension (combinational) ----
    assign fld_d  = $signed(instr[20:12]);
    assign fld_b  = $signed(instr[25:0]);
    assign fld_cb = $signed(instr[23:5]);

    assign ext_i  = OUT_W'(instr[21:10]);
    assign ext_d  = OUT_W'(fld_d);
    assign ext_b  = br_scale(OUT_W'(fld_b));
    assign ext_cb = br_scale(OUT_W'(fld_cb));
    // Overflowing halfword shifts are flagged illegal, so truncation here never matters.
    assign ext_iw = OUT_W'(instr[20:5]) << {instr[22:21], 4'b0000};

    assign unused_opcode = ^instr[31:26];

    always_comb begin
        imm_p0 = '0;
        ill_p0 = 1'b0;
        case (fmt)
            FMT_I:  imm_p0 = ext_i;
            FMT_D:  imm_p0 = ext_d;
            FMT_B:  imm_p0 = ext_b;
            FMT_CB: imm_p0 = ext_cb;
            FMT_IW: begin
                if (iw_legal(instr[22:21])) imm_p0 = ext_iw;
                else                        ill_p0 = 1'b1;
            end
            default: ill_p0 = 1'b1;
        endcase
    end

    // ---- stage p1: ID/EX output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= EMPTY;
            imm_p1   <= '0;
            err_p1   <= 1'b0;
            cnt_p1   <= '0;
        end else if (flush) begin
            state_p1 <= EMPTY;
            imm_p1   <= '0;
            err_p1   <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                state_p1 <= FULL;
                imm_p1   <= imm_p0;
                err_p1   <= ill_p0;
                if (ill_p0) cnt_p1 <= sat_inc(cnt_p1);
            end else begin
                state_p1 <= EMPTY;
                imm_p1   <= '0;
                err_p1   <= 1'b0;
            end
        end
    end

    assign out_valid = (state_p1 == FULL);
    assign imm       = imm_p1;
    assign out_err   = err_p1;
    assign err_cnt   = cnt_p1;

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Registered immediate extractor/extender for the decode stage of the pipelined LEGv8 CPU. It generalises fixed-width sign extension: it selects the immediate field for the instruction format and applies sign- or zero-extension to a parametrised output width. For MOVZ/MOVK it applies the halfword shift, and it counts illegal format requests. The result is held in a stall/flush-aware pipeline register feeding the ID/EX boundary.

## Interface
- `OUT_W`, 64, output immediate width; legal values are 32 and 64.
- `CNT_W`, 8, width of the saturating illegal-format counter.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  the current `instr`/`fmt` pair is valid.
- `instr`  input  32  raw instruction word.
- `fmt`  input  3  format select: 0=I, 1=D, 2=B, 3=CB, 4=IW, 5–7 reserved.
- `stall`  input  1  hold the output register.
- `flush`  input  1  invalidate the output register.
- `out_valid`  output  1  `imm` and `out_err` are valid.
- `imm`  output  OUT_W  extended immediate.
- `out_err`  output  1  the captured request was illegal.
- `err_cnt`  output  CNT_W  saturating count of captured illegal requests.

## Operation
- Field extraction and extension per format:
  - I: `instr[21:10]`, 12 bits, zero-extended.
  - D: `instr[20:12]`, 9 bits, sign-extended.
  - B: `instr[25:0]`, 26 bits, sign-extended.
  - CB: `instr[23:5]`, 19 bits, sign-extended.
  - IW: `instr[20:5]`, 16 bits, zero-extended, then shifted left by 16×`instr[22:21]`.
- Illegal request: `fmt` is 5–7, or the format is IW with 16×hw+16 > OUT_W (hw 2 or 3 when OUT_W=32).
  - An illegal request produces `imm`=0 and `out_err`=1.
  - A legal request produces `out_err`=0.
- Output register update priority, highest first:
  1. `reset`: `out_valid`=0, `imm`=0, `out_err`=0, `err_cnt`=0.
  2. `flush`: `out_valid`=0, `imm`=0, `out_err`=0; `err_cnt` unchanged. Flush overrides stall.
  3. `stall`: all outputs hold, including `err_cnt`.
  4. Otherwise: `out_valid`←`in_valid`. If `in_valid`=1, load `imm` and `out_err`. If `in_valid`=0, `imm` and `out_err` are cleared to 0.
- `err_cnt` increments only in case 4 when `in_valid`=1 and the request is illegal. It saturates at 2^CNT_W−1 and never wraps.
- Illegal requests dropped by `flush` or `stall` are not counted.
- Internal two-state view: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on a load with `in_valid`=1.
  - FULL→EMPTY on `flush`, or on a load with `in_valid`=0.
  - FULL→FULL on `stall`, or on a load with `in_valid`=1.
- Arithmetic:
  - Sign extension replicates the field MSB up to bit OUT_W−1.
  - The IW shift is computed at OUT_W width; no bits are lost because overflowing shifts are classified illegal.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- All outputs come straight from registers; there is no combinational path from input to output.
- Reset takes effect at the first rising edge with `reset`=1, including mid-stall. Outputs after that edge match the reset values above.
- A stall held for any number of cycles keeps `imm` bit-identical throughout.
- `stall` and `flush` asserted together: flush wins at that edge.

## Configuration
- `IMM_BR_SHIFT_EN` defined: B and CB results are shifted left by 2 after sign extension, giving byte offsets. Bits shifted past OUT_W−1 are discarded.
- `IMM_BR_SHIFT_EN` undefined: B and CB results are word offsets, unshifted.
- The macro has no effect on the I, D and IW formats, on error detection, or on timing.

## Test plan
- Reset: hold `reset`=1 with `in_valid`=1, `fmt`=1 for 2 cycles → `out_valid`=0, `imm`=0, `out_err`=0, `err_cnt`=0 after each edge.
- D sign extension: `fmt`=1, `instr[20:12]`=9'h1FF → next cycle `imm`=64'hFFFF_FFFF_FFFF_FFFF, `out_valid`=1. Then `instr[20:12]`=9'h0FF → `imm`=64'h0000_0000_0000_00FF.
- B format: `fmt`=2, `instr[25:0]`=26'h200_0000.
  - Without the macro: `imm`=64'hFFFF_FFFF_FE00_0000.
  - With `IMM_BR_SHIFT_EN`: `imm`=64'hFFFF_FFFF_F800_0000.
  - CB format, `instr[23:5]`=19'h00010: `imm`=64'h10 without the macro, 64'h40 with it.
- IW shift: `fmt`=4, `instr[20:5]`=16'hBEEF, `instr[22:21]`=2.
  - OUT_W=64 → `imm`=64'h0000_BEEF_0000_0000.
  - OUT_W=32 → `imm`=0, `out_err`=1, `err_cnt`=1.
- Stall and flush: load I-format `instr[21:10]`=12'hABC → `imm`=64'hABC.
  - Assert `stall` for 3 cycles while changing `instr` → `imm` stays 64'hABC and `out_valid` stays 1.
  - Assert `stall`+`flush` together → `out_valid`=0, `imm`=0.
- Error counter: 300 consecutive captured requests with `fmt`=6 → `err_cnt` reaches 255 and holds at 255; `imm`=0 and `out_err`=1 each cycle.
  - A `fmt`=7 request arriving with `flush`=1 does not change `err_cnt`.
